inst_prefetch: RTL and testbench

//  Instruction prefetch queue sitting directly upstream of the control unit on the
//  16-bit, word-addressed instruction path. Fetches words from memory ahead of use

---
 rtl/inst_prefetch_pkg.sv | 20 ++
 rtl/inst_prefetch_sync_fifo.sv | 74 +++++++
 rtl/inst_prefetch.sv | 95 +++++++++
 tb/tb_inst_prefetch.sv | 131 +++++++++++++
 4 files changed

// File: rtl/inst_prefetch_pkg.sv
// Shared types for the 16-bit word-addressed instruction fetch path.
package inst_prefetch_pkg;

    localparam int PC_W   = 7;
    localparam int WORD_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [WORD_W-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t word;
    } fetch_entry_t;

    // Byte address of a word-addressed PC (memory port is byte addressed).
    function automatic logic [PC_W:0] byte_addr(input pc_t pc);
        return {pc, 1'b0};
    endfunction

endpackage

// File: rtl/inst_prefetch_sync_fifo.sv
// Generic synchronous FIFO of fetch entries: registered storage, combinational
// head, flush clears pointers and occupancy in one cycle.
module inst_prefetch_sync_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Next-state for storage, pointers and occupancy; flush beats push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches ahead while the memory port is idle,
// presents PC-tagged words via valid/ready, flushes on a taken redirect.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_busy,
    input  logic [WORD_W-1:0] mem_out,
    output logic [PC_W:0]     mem_addr,
    output logic              mem_re,
    output logic [WORD_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc
);

    localparam int                 AW       = $clog2(DEPTH);
    localparam logic [AW:0]        FULL_CNT = (AW+1)'(DEPTH);

    pc_t              fetch_pc_q, fetch_pc_d;
    logic [AW:0]      fifo_count_s;
    fetch_entry_t     fifo_head_s;
    fetch_entry_t     fifo_din_s;
    logic             head_valid_s;
    logic             pop_s;
    logic             fetch_s;

    // Request and handshake decode; a redirect suppresses both fetch and pop.
    always_comb begin
        head_valid_s = (fifo_count_s != '0);
        pop_s        = head_valid_s & inst_ready & ~redirect;
        fetch_s      = ~rst & ~mem_busy & ~redirect &
                       ((fifo_count_s != FULL_CNT) | pop_s);
        fifo_din_s   = '{pc: fetch_pc_q, word: mem_out};
        if (fetch_s) begin
            mem_addr = byte_addr(fetch_pc_q);
        end else begin
            mem_addr = '0;
        end
    end

    // Fetch PC: redirect reloads it, a fetch advances it (wraps mod 2^PC_W).
    always_comb begin
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (fetch_s) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch PC register; reset wins over redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    inst_prefetch_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch_s),
        .pop   (pop_s),
        .flush (redirect),
        .din   (fifo_din_s),
        .head  (fifo_head_s),
        .count (fifo_count_s)
    );

    // Consumer view of the head; zeroed when the queue is empty.
    always_comb begin
        if (head_valid_s) begin
            inst       = fifo_head_s.word;
            inst_pc    = fifo_head_s.pc;
            inst_valid = 1'b1;
        end else begin
            inst       = '0;
            inst_pc    = '0;
            inst_valid = 1'b0;
        end
    end

    assign mem_re = fetch_s;

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: a reference queue model predicts
// fetch requests and the head entry every cycle.
module tb_inst_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_busy = 1'b0;
    logic [15:0] mem_out;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic [15:0] inst;
    logic [6:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [6:0]  redirect_pc = 7'd0;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected queue contents {pc, word}, oldest first.
    logic [22:0] sb_q[$];
    logic [6:0]  m_fetch_pc = 7'd0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [6:0] pc);
        return {pc, 9'h000} ^ 16'h5A3C;
    endfunction

    assign mem_out = mem_word(mem_addr[7:1]);

    inst_prefetch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_busy    (mem_busy),
        .mem_out     (mem_out),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare combinational outputs, advance model.
    task automatic step(input logic r, input logic b, input logic rd,
                        input logic rdr, input logic [6:0] rpc, input bit do_chk);
        bit          e_valid, e_pop, e_re;
        logic [22:0] head;
        rst = r; mem_busy = b; inst_ready = rd; redirect = rdr; redirect_pc = rpc;
        #3;
        e_valid = (sb_q.size() > 0);
        head    = e_valid ? sb_q[0] : 23'd0;
        e_pop   = e_valid && rd && !rdr;
        e_re    = !r && !b && !rdr && ((sb_q.size() < DEPTH) || e_pop);
        if (do_chk) begin
            check_val("mem_re",     {31'd0, mem_re},     {31'd0, e_re});
            check_val("mem_addr",   {24'd0, mem_addr},   e_re ? {24'd0, m_fetch_pc, 1'b0} : 32'd0);
            check_val("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
            check_val("inst",       {16'd0, inst},       {16'd0, head[15:0]});
            check_val("inst_pc",    {25'd0, inst_pc},    {25'd0, head[22:16]});
        end
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            m_fetch_pc = 7'd0;
        end else if (rdr) begin
            sb_q.delete();
            m_fetch_pc = rpc;
        end else begin
            if (e_pop) void'(sb_q.pop_front());
            if (e_re) begin
                sb_q.push_back({m_fetch_pc, mem_word(m_fetch_pc)});
                m_fetch_pc = m_fetch_pc + 7'd1;
            end
        end
    endtask

    initial begin
        // Reset (first cycle unchecked: state not yet initialised).
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        // Fill to full with no consumer: addresses 0,2,4,6 then stall.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        check_val("full_head_pc", {25'd0, inst_pc}, 32'd0);
        // Single pop on full queue: pop pc0, push pc4.
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        check_val("after_pop_head_pc", {25'd0, inst_pc}, 32'd1);
        // Steady streaming.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        // Redirect to 0x20 with consumer ready.
        step(1'b0, 1'b0, 1'b1, 1'b1, 7'h20, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        // PC wrap: redirect to 126 and stream.
        step(1'b0, 1'b0, 1'b1, 1'b1, 7'd126, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        // Fill, then drain under mem_busy.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);
        check_val("drained_inst", {16'd0, inst}, 32'd0);
        // Redirect to the current fetch PC still flushes.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, m_fetch_pc, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 7'($urandom_range(0, 127)), 1'b1);
        end
        // Reset together with redirect: fetch restarts at 0.
        step(1'b1, 1'b0, 1'b1, 1'b1, 7'h55, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
